// File: rtl/cv_sched_pkg.sv
// Shared definitions for the convolution weight-read scheduler.
//   sched_state_e         : scheduler FSM states
//   MODE_8B / MODE_1B     : cfg_mode encodings (8-bit / 1-bit weights)
//   MODE1_BEATS_PER_WORD  : read beats that share one weight word in 1-bit mode
package cv_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_BURST = 3'd2,
    ST_END   = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } sched_state_e;

  localparam logic MODE_8B = 1'b0;
  localparam logic MODE_1B = 1'b1;

  localparam int MODE1_BEATS_PER_WORD = 4;

endpackage

// File: rtl/cv_tile_addr_gen.sv
// Tile index and per-tile weight base address tracker.
//   clk, reset      : clock, asynchronous active-high reset
//   load            : start of layer; tile 0 at base_adr
//   advance         : terminating beat of a tile fired; step to the next tile
//   mode, beats     : latched layer config used to size one tile in words
//   base_adr        : latched weight address of tile 0
//   weight_base_adr : base address of the current tile (wraps mod 2^ADR_W)
//   tile_idx        : current tile index
module cv_tile_addr_gen
  import cv_sched_pkg::*;
#(
  parameter int BEAT_W = 16,
  parameter int TILE_W = 12,
  parameter int ADR_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic              mode,
  input  logic [BEAT_W-1:0] beats,
  input  logic [ADR_W-1:0]  base_adr,
  output logic [ADR_W-1:0]  weight_base_adr,
  output logic [TILE_W-1:0] tile_idx
);

  localparam int SUM_W = BEAT_W + 1;

  logic [SUM_W-1:0]  words_1b;
  logic [ADR_W-1:0]  words;
  logic [ADR_W-1:0]  weight_base_adr_d, weight_base_adr_q;
  logic [TILE_W-1:0] tile_idx_d, tile_idx_q;

  always_comb begin
    // One extra bit so the round-up addition cannot overflow.
    words_1b = ({1'b0, beats} + SUM_W'(MODE1_BEATS_PER_WORD - 1))
               / SUM_W'(MODE1_BEATS_PER_WORD);
    words    = (mode == MODE_1B) ? ADR_W'(words_1b) : ADR_W'(beats);

    weight_base_adr_d = weight_base_adr_q;
    tile_idx_d        = tile_idx_q;
    if (load) begin
      weight_base_adr_d = base_adr;
      tile_idx_d        = '0;
    end else if (advance) begin
      weight_base_adr_d = weight_base_adr_q + words;
      tile_idx_d        = tile_idx_q + TILE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_base_adr_q <= '0;
      tile_idx_q        <= '0;
    end else begin
      weight_base_adr_q <= weight_base_adr_d;
      tile_idx_q        <= tile_idx_d;
    end
  end

  assign weight_base_adr = weight_base_adr_q;
  assign tile_idx        = tile_idx_q;

endmodule

// File: rtl/cv_weight_read_scheduler.sv
// Convolution weight-read scheduler for one layer.
// Per tile it issues cfg_beats read beats followed by one terminating beat
// (re_fm_en with re_fm_end), throttled by pe_ready, then GAP_CYCLES idle
// cycles so the handler and PE pipeline drain.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   start                       : layer start pulse, honoured only in IDLE
//   cfg_mode/beats/tiles/base_adr : layer config, latched on accepted start
//   pe_ready                    : downstream can take a weight vector
//   re_fm_en, re_fm_end         : read enable / end-of-tile to weight handler
//   weight_base_adr, tile_idx   : current tile base address and index
//   busy, done, err_cfg         : status to the layer controller
//   perf_stall_cnt              : stall cycle counter (only with CV_WSCHED_PERF_EN)
// Optional feature macro: CV_WSCHED_PERF_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_LOAD  | config check, tile 0 setup
// ST_BURST | plain read beats of the current tile
// ST_END   | terminating beat, held until pe_ready
// ST_GAP   | drain cycles after each tile
// ST_DONE  | one-cycle done (and err_cfg on a bad config)
module cv_weight_read_scheduler
  import cv_sched_pkg::*;
#(
  parameter int BEAT_W     = 16,
  parameter int TILE_W     = 12,
  parameter int ADR_W      = 11,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_mode,
  input  logic [BEAT_W-1:0] cfg_beats,
  input  logic [TILE_W-1:0] cfg_tiles,
  input  logic [ADR_W-1:0]  cfg_base_adr,
  input  logic              pe_ready,
  output logic              re_fm_en,
  output logic              re_fm_end,
  output logic [ADR_W-1:0]  weight_base_adr,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done,
  output logic              err_cfg
`ifdef CV_WSCHED_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sched_state_e      state_d, state_q;
  logic [BEAT_W-1:0] beat_cnt_d, beat_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_d, gap_cnt_q;
  logic              err_d, err_q;
  logic              cfg_mode_d, cfg_mode_q;
  logic [BEAT_W-1:0] cfg_beats_d, cfg_beats_q;
  logic [TILE_W-1:0] cfg_tiles_d, cfg_tiles_q;
  logic [ADR_W-1:0]  cfg_base_adr_d, cfg_base_adr_q;

  logic              addr_load;
  logic              addr_adv;
  logic [TILE_W:0]   tile_next_ext;
  logic              more_after_end;
  logic              more_in_gap;

  cv_tile_addr_gen #(
    .BEAT_W (BEAT_W),
    .TILE_W (TILE_W),
    .ADR_W  (ADR_W)
  ) u_addr_gen (
    .clk             (clk),
    .reset           (reset),
    .load            (addr_load),
    .advance         (addr_adv),
    .mode            (cfg_mode_q),
    .beats           (cfg_beats_q),
    .base_adr        (cfg_base_adr_q),
    .weight_base_adr (weight_base_adr),
    .tile_idx        (tile_idx)
  );

  // In END the index has not advanced yet, so look one tile ahead.
  assign tile_next_ext  = {1'b0, tile_idx} + (TILE_W + 1)'(1);
  assign more_after_end = tile_next_ext < {1'b0, cfg_tiles_q};
  assign more_in_gap    = tile_idx < cfg_tiles_q;

  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    err_d          = err_q;
    cfg_mode_d     = cfg_mode_q;
    cfg_beats_d    = cfg_beats_q;
    cfg_tiles_d    = cfg_tiles_q;
    cfg_base_adr_d = cfg_base_adr_q;
    re_fm_en       = 1'b0;
    re_fm_end      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    err_cfg        = 1'b0;
    addr_load      = 1'b0;
    addr_adv       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_mode_d     = cfg_mode;
          cfg_beats_d    = cfg_beats;
          cfg_tiles_d    = cfg_tiles;
          cfg_base_adr_d = cfg_base_adr;
          err_d          = 1'b0;
          state_d        = ST_LOAD;
        end
      end

      ST_LOAD: begin
        busy = 1'b1;
        if (cfg_beats_q == '0 || cfg_tiles_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          addr_load  = 1'b1;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end

      ST_BURST: begin
        busy     = 1'b1;
        re_fm_en = pe_ready;
        if (pe_ready) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (beat_cnt_q == cfg_beats_q - BEAT_W'(1)) begin
            state_d = ST_END;
          end
        end
      end

      ST_END: begin
        busy      = 1'b1;
        re_fm_en  = pe_ready;
        re_fm_end = pe_ready;
        if (pe_ready) begin
          addr_adv = 1'b1;
          if (GAP_CYCLES > 0) begin
            gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
            state_d   = ST_GAP;
          end else if (more_after_end) begin
            beat_cnt_d = '0;
            state_d    = ST_BURST;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_GAP: begin
        busy = 1'b1;
        if (gap_cnt_q == '0) begin
          if (more_in_gap) begin
            beat_cnt_d = '0;
            state_d    = ST_BURST;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        err_cfg = err_q;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      beat_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      err_q          <= 1'b0;
      cfg_mode_q     <= 1'b0;
      cfg_beats_q    <= '0;
      cfg_tiles_q    <= '0;
      cfg_base_adr_q <= '0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      err_q          <= err_d;
      cfg_mode_q     <= cfg_mode_d;
      cfg_beats_q    <= cfg_beats_d;
      cfg_tiles_q    <= cfg_tiles_d;
      cfg_base_adr_q <= cfg_base_adr_d;
    end
  end

`ifdef CV_WSCHED_PERF_EN
  logic [31:0] perf_stall_cnt_d, perf_stall_cnt_q;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (state_q == ST_IDLE && start) begin
      perf_stall_cnt_d = '0;
    end else if ((state_q == ST_BURST || state_q == ST_END) && !pe_ready &&
                 perf_stall_cnt_q != '1) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_stall_cnt_q <= '0;
    else       perf_stall_cnt_q <= perf_stall_cnt_d;
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_cv_weight_read_scheduler.sv
// Scoreboard bench for cv_weight_read_scheduler: a layer-level model pushes
// the expected beat/done sequence, a negedge monitor pops it whenever the DUT
// fires a beat or pulses done. Cycle-exact timing is checked for runs with
// pe_ready held high.
module tb_cv_weight_read_scheduler;

  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cfg_mode;
  logic [15:0] cfg_beats;
  logic [11:0] cfg_tiles;
  logic [10:0] cfg_base_adr;
  logic        pe_ready;
  logic        re_fm_en;
  logic        re_fm_end;
  logic [10:0] weight_base_adr;
  logic [11:0] tile_idx;
  logic        busy;
  logic        done;
  logic        err_cfg;
`ifdef CV_WSCHED_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  cv_weight_read_scheduler #(
    .BEAT_W(16), .TILE_W(12), .ADR_W(11), .GAP_CYCLES(GAP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .cfg_mode        (cfg_mode),
    .cfg_beats       (cfg_beats),
    .cfg_tiles       (cfg_tiles),
    .cfg_base_adr    (cfg_base_adr),
    .pe_ready        (pe_ready),
    .re_fm_en        (re_fm_en),
    .re_fm_end       (re_fm_end),
    .weight_base_adr (weight_base_adr),
    .tile_idx        (tile_idx),
    .busy            (busy),
    .done            (done),
    .err_cfg         (err_cfg)
`ifdef CV_WSCHED_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_done;
    logic        endb;
    logic        err;
    logic [10:0] base;
    logic [11:0] tidx;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_tidx  = 0;
  int   m_base  = 0;

  // Expected output sequence of one layer, from the layer's config alone.
  function automatic void push_expect(input logic mode, input int beats,
                                      input int tiles, input int base);
    exp_t e;
    int   w;
    if (beats == 0 || tiles == 0) begin
      e.is_done = 1'b1; e.endb = 1'b0; e.err = 1'b1;
      e.base = 11'(m_base); e.tidx = 12'(m_tidx);
      sbq.push_back(e);
      return;
    end
    w = mode ? (beats + 3) / 4 : beats;
    for (int t = 0; t < tiles; t++) begin
      for (int i = 0; i <= beats; i++) begin
        e.is_done = 1'b0; e.endb = (i == beats); e.err = 1'b0;
        e.base = 11'((base + t * w) % 2048); e.tidx = 12'(t);
        sbq.push_back(e);
      end
    end
    m_tidx = tiles % 4096;
    m_base = (base + tiles * w) % 2048;
    e.is_done = 1'b1; e.endb = 1'b0; e.err = 1'b0;
    e.base = 11'(m_base); e.tidx = 12'(m_tidx);
    sbq.push_back(e);
  endfunction

  // Cycle k after the start cycle (k=0) with pe_ready always high.
  function automatic void exp_timing(input int k, input int beats, input int tiles,
                                     output bit en, output bit ed, output bit bsy,
                                     output bit dn, output bit er);
    int p, dk, r;
    en = 0; ed = 0; bsy = 0; dn = 0; er = 0;
    if (beats == 0 || tiles == 0) begin
      bsy = (k == 1); dn = (k == 2); er = (k == 2);
      return;
    end
    p  = beats + 1 + GAP;
    dk = 2 + tiles * p;
    bsy = (k >= 1 && k < dk);
    dn  = (k == dk);
    if (k >= 2 && k < dk) begin
      r  = (k - 2) % p;
      en = (r <= beats);
      ed = (r == beats);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (re_fm_end) begin
        n_tests++;
        if (!re_fm_en) begin
          n_fail++;
          $display("FAIL end_without_en re_fm_end=%b re_fm_en=%b", re_fm_end, re_fm_en);
        end
      end
      if (re_fm_en || done) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected en=%b done=%b tile=%0d adr=%h", re_fm_en, done,
                   tile_idx, weight_base_adr);
        end else begin
          mon_e = sbq.pop_front();
          if (re_fm_en) begin
            if (mon_e.is_done || mon_e.endb != re_fm_end || mon_e.base != weight_base_adr ||
                mon_e.tidx != tile_idx) begin
              n_fail++;
              $display("FAIL sb_beat got end=%b adr=%h tile=%0d exp done=%b end=%b adr=%h tile=%0d",
                       re_fm_end, weight_base_adr, tile_idx, mon_e.is_done, mon_e.endb,
                       mon_e.base, mon_e.tidx);
            end
          end else begin
            if (!mon_e.is_done || mon_e.err != err_cfg || mon_e.base != weight_base_adr ||
                mon_e.tidx != tile_idx || busy) begin
              n_fail++;
              $display("FAIL sb_done got err=%b adr=%h tile=%0d busy=%b exp done=%b err=%b adr=%h tile=%0d",
                       err_cfg, weight_base_adr, tile_idx, busy, mon_e.is_done, mon_e.err,
                       mon_e.base, mon_e.tidx);
            end
          end
        end
      end
    end
  end

  // pe_sel: 0 = always ready, 1 = random ready, 2 = fixed stall pattern.
  task automatic run_layer(input logic mode, input int beats, input int tiles,
                           input int base, input int pe_sel, input bit tchk,
                           input bit disturb);
    bit seen_done;
    bit e_en, e_ed, e_bsy, e_dn, e_er;
    push_expect(mode, beats, tiles, base);
    cfg_mode     = mode;
    cfg_beats    = 16'(beats);
    cfg_tiles    = 12'(tiles);
    cfg_base_adr = 11'(base);
    seen_done    = 0;
    for (int k = 0; k < 3000 && !seen_done; k++) begin
      @(posedge clk); #1;
      start = (k == 0) || (disturb && k == 3);
      if (disturb && k == 4) begin
        cfg_beats    = 16'($urandom_range(1, 9));
        cfg_tiles    = 12'($urandom_range(1, 5));
        cfg_mode     = ~cfg_mode;
        cfg_base_adr = 11'($urandom);
      end
      case (pe_sel)
        0:       pe_ready = 1'b1;
        1:       pe_ready = ($urandom_range(0, 99) < 70);
        default: pe_ready = !(k inside {4, 5, 6, 9, 10});
      endcase
      @(negedge clk);
      if (tchk) begin
        exp_timing(k, beats, tiles, e_en, e_ed, e_bsy, e_dn, e_er);
        n_tests++;
        if ({re_fm_en, re_fm_end, busy, done, err_cfg} != {e_en, e_ed, e_bsy, e_dn, e_er}) begin
          n_fail++;
          $display("FAIL timing k=%0d got en/end/busy/done/err=%b%b%b%b%b exp=%b%b%b%b%b", k,
                   re_fm_en, re_fm_end, busy, done, err_cfg, e_en, e_ed, e_bsy, e_dn, e_er);
        end
      end
      if (done) seen_done = 1;
    end
    @(posedge clk); #1;
    start    = 1'b0;
    pe_ready = 1'b1;
    n_tests++;
    if (!seen_done) begin
      n_fail++;
      $display("FAIL layer_timeout done_seen=%b required=1", seen_done);
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain left=%0d required=0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    bit found;
    reset = 1'b1; start = 1'b0; pe_ready = 1'b1;
    cfg_mode = 1'b0; cfg_beats = '0; cfg_tiles = '0; cfg_base_adr = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({re_fm_en, re_fm_end, busy, done, err_cfg} != 5'b0 || tile_idx != 0 ||
        weight_base_adr != 0) begin
      n_fail++;
      $display("FAIL reset_vals en/end/busy/done/err=%b%b%b%b%b tile=%0d adr=%h required all 0",
               re_fm_en, re_fm_end, busy, done, err_cfg, tile_idx, weight_base_adr);
    end
`ifdef CV_WSCHED_PERF_EN
    n_tests++;
    if (perf_stall_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_perf got=%0d required=0", perf_stall_cnt);
    end
`endif
    reset = 1'b0;

    run_layer(1'b0, 3, 2, 'h010, 0, 1, 0);
    run_layer(1'b1, 6, 3, 0, 0, 1, 0);
    run_layer(1'b0, 4, 1, 'h100, 2, 0, 0);
`ifdef CV_WSCHED_PERF_EN
    n_tests++;
    if (perf_stall_cnt != 32'd5) begin
      n_fail++;
      $display("FAIL perf_stall got=%0d required=5", perf_stall_cnt);
    end
`endif
    run_layer(1'b0, 5, 0, 'h123, 0, 1, 0);
    run_layer(1'b1, 0, 3, 'h321, 0, 1, 0);
    run_layer(1'b0, 4, 2, 'h7FE, 0, 1, 0);
    run_layer(1'b0, 5, 2, 'h020, 0, 1, 1);
    run_layer(1'b0, 1, 3, 'h055, 0, 1, 0);

    // Reset during a burst of tile 1.
    push_expect(1'b0, 2, 3, 100);
    cfg_mode = 1'b0; cfg_beats = 16'd2; cfg_tiles = 12'd3; cfg_base_adr = 11'd100;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (re_fm_en && tile_idx == 12'd1) found = 1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_wait reached_tile1_beat=%b required=1", found);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (re_fm_en || busy || tile_idx != 0 || weight_base_adr != 0 || done) begin
      n_fail++;
      $display("FAIL reset_mid en=%b busy=%b tile=%0d adr=%h done=%b required all 0",
               re_fm_en, busy, tile_idx, weight_base_adr, done);
    end
    sbq.delete();
    m_tidx = 0;
    m_base = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_layer(1'b1, 5, 2, 'h040, 0, 1, 0);

    for (int r = 0; r < 12; r++) begin
      run_layer(1'($urandom_range(0, 1)), $urandom_range(1, 9), $urandom_range(1, 4),
                $urandom_range(0, 2047), 1, 0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
